// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan capture block.
// Holds the digit pattern constants, the capture FSM state type, the
// registered input-sample payload and small one-hot helpers.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned SEG_W      = 8;

    localparam logic [BCD_W-1:0] BCD_INVALID = 4'hF;

    // Segment patterns for decimal digits 0-9
    localparam logic [SEG_W-1:0] SEG_0 = 8'hfc;
    localparam logic [SEG_W-1:0] SEG_1 = 8'h60;
    localparam logic [SEG_W-1:0] SEG_2 = 8'hda;
    localparam logic [SEG_W-1:0] SEG_3 = 8'hf2;
    localparam logic [SEG_W-1:0] SEG_4 = 8'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 8'hb6;
    localparam logic [SEG_W-1:0] SEG_6 = 8'hbe;
    localparam logic [SEG_W-1:0] SEG_7 = 8'he0;
    localparam logic [SEG_W-1:0] SEG_8 = 8'hfe;
    localparam logic [SEG_W-1:0] SEG_9 = 8'hf6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_e;

    // One registered observation of the scanned display bus
    typedef struct packed {
        logic [NUM_DIGITS-1:0] an;
        logic [SEG_W-1:0]      seg_lo;
        logic [SEG_W-1:0]      seg_hi;
    } scan_sample_t;

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    // Index of the set bit; only meaningful when v is one-hot
    function automatic logic [2:0] onehot_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (v[k]) idx = 3'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to BCD decoder.
// Ports:
//   seg  - 8-bit segment pattern
//   bcd  - decoded digit 0-9, BCD_INVALID when the pattern is unknown
//   hit  - high when seg is one of the ten digit patterns
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [BCD_W-1:0] bcd,
    output logic             hit
);

    always_comb begin
        bcd = BCD_INVALID;
        hit = 1'b1;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Reconstructs the eight BCD digits shown on a multiplexed 7-segment
// display by sniffing its digit-select and segment buses. Samples are
// gathered into a shadow frame; once all eight digits have been seen the
// frame is committed to the outputs in a single cycle.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   an                 - one-hot digit select (0 = blank)
//   segout_0/segout_1  - segment bus for digits 0-3 / 4-7
//   digit0..digit7     - committed BCD digits
//   digit_valid        - per-digit decoded flag
//   frame_done         - one-cycle pulse when new digits appear
//   stale              - one-cycle pulse when a partial frame is abandoned
//   err, err_count     - illegal-sample pulse and saturating count
//
// Define SEG7_CAPTURE_ERR_EN to flag illegal samples; otherwise they are
// silently ignored and err/err_count stay 0.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int unsigned FRAME_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  an,
    input  logic [7:0]  segout_0,
    input  logic [7:0]  segout_1,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic [3:0]  digit4,
    output logic [3:0]  digit5,
    output logic [3:0]  digit6,
    output logic [3:0]  digit7,
    output logic [7:0]  digit_valid,
    output logic        frame_done,
    output logic        stale,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam int unsigned CNT_W = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [7:0]  ERR_MAX = 8'hFF;

    state_e                              state_q, state_d;
    scan_sample_t                        s1_q;
    logic [NUM_DIGITS-1:0]               mask_q, mask_d;
    logic [NUM_DIGITS-1:0]               sval_q, sval_d;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]    shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]    digits_q, digits_d;
    logic [NUM_DIGITS-1:0]               dvalid_q, dvalid_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic                                frame_done_q, frame_done_d;
    logic                                stale_q, stale_d;
    logic                                err_q, err_d;
    logic [7:0]                          err_cnt_q, err_cnt_d;

    logic [2:0]            idx;
    logic [SEG_W-1:0]      sel_seg;
    logic [BCD_W-1:0]      dec_bcd;
    logic                  dec_hit;
    logic                  onehot;
    logic                  legal;
    logic                  illegal;
    logic                  bad_slot;
    logic [NUM_DIGITS-1:0] mask_base;
    logic [NUM_DIGITS-1:0] sval_base;

    // Pick the segment bus that drives the selected digit
    always_comb begin
        onehot  = is_onehot8(s1_q.an);
        idx     = onehot_index(s1_q.an);
        sel_seg = idx[2] ? s1_q.seg_hi : s1_q.seg_lo;
    end

    seg7_pattern_decode u_decode (
        .seg (sel_seg),
        .bcd (dec_bcd),
        .hit (dec_hit)
    );

    // Sample classification
    always_comb begin
        legal = onehot && dec_hit;
`ifdef SEG7_CAPTURE_ERR_EN
        illegal  = (s1_q.an != 8'd0) && !legal;
        bad_slot = onehot && !dec_hit;
`else
        illegal  = 1'b0;
        bad_slot = 1'b0;
`endif
    end

    // Next-state and datapath logic
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        digits_d     = digits_q;
        dvalid_d     = dvalid_q;
        cnt_d        = cnt_q;
        err_cnt_d    = err_cnt_q;
        frame_done_d = 1'b0;
        stale_d      = 1'b0;
        err_d        = 1'b0;

        // The commit cycle opens a fresh frame, so its sample lands in an empty mask
        mask_base = (state_q == COMMIT) ? '0 : mask_q;
        sval_base = (state_q == COMMIT) ? '0 : sval_q;
        mask_d    = mask_base;
        sval_d    = sval_base;

        if (legal) begin
            mask_d[idx]   = 1'b1;
            sval_d[idx]   = 1'b1;
            shadow_d[idx] = dec_bcd;
        end else if (bad_slot) begin
            mask_d[idx]   = 1'b1;
            sval_d[idx]   = 1'b0;
            shadow_d[idx] = BCD_INVALID;
        end

        if (illegal) begin
            err_d = 1'b1;
            if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (legal) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                end
            end
            COLLECT: begin
                // A completed frame takes priority over an expiring timer
                if (mask_d == 8'hFF) begin
                    state_d = COMMIT;
                end else if (cnt_q == CNT_W'(FRAME_TIMEOUT)) begin
                    state_d = IDLE;
                    stale_d = 1'b1;
                    mask_d  = '0;
                    sval_d  = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            COMMIT: begin
                digits_d     = shadow_q;
                dvalid_d     = sval_q;
                frame_done_d = 1'b1;
                cnt_d        = '0;
                state_d      = COLLECT;
            end
            default: begin
                state_d = IDLE;
                mask_d  = '0;
                sval_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            s1_q         <= '0;
            mask_q       <= '0;
            sval_q       <= '0;
            shadow_q     <= '0;
            digits_q     <= '0;
            dvalid_q     <= '0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
            stale_q      <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            s1_q         <= '{an: an, seg_lo: segout_0, seg_hi: segout_1};
            mask_q       <= mask_d;
            sval_q       <= sval_d;
            shadow_q     <= shadow_d;
            digits_q     <= digits_d;
            dvalid_q     <= dvalid_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
            stale_q      <= stale_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign digit0      = digits_q[0];
    assign digit1      = digits_q[1];
    assign digit2      = digits_q[2];
    assign digit3      = digits_q[3];
    assign digit4      = digits_q[4];
    assign digit5      = digits_q[5];
    assign digit6      = digits_q[6];
    assign digit7      = digits_q[7];
    assign digit_valid = dvalid_q;
    assign frame_done  = frame_done_q;
    assign stale       = stale_q;
    assign err         = err_q;
    assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Self-checking bench for seg7_scan_capture: table-driven full frames plus
// directed sequences for loopback scanning, overwrite, timeout, illegal
// samples and mid-frame reset.
module tb_seg7_scan_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] an, segout_0, segout_1;
    logic [3:0] digit0, digit1, digit2, digit3, digit4, digit5, digit6, digit7;
    logic [7:0] digit_valid;
    logic       frame_done, stale, err;
    logic [7:0] err_count;

    seg7_scan_capture #(.FRAME_TIMEOUT(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .an          (an),
        .segout_0    (segout_0),
        .segout_1    (segout_1),
        .digit0      (digit0),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .digit4      (digit4),
        .digit5      (digit5),
        .digit6      (digit6),
        .digit7      (digit7),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .stale       (stale),
        .err         (err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    logic [31:0] dig_bus;
    assign dig_bus = {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fd_seen  = 0;
    int st_seen  = 0;
    int err_seen = 0;
    int fd_cyc[$];

    // Pulse bookkeeping, sampled mid-cycle
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (frame_done === 1'b1) begin
            fd_seen = fd_seen + 1;
            fd_cyc.push_back(cyc);
        end
        if (stale === 1'b1) st_seen = st_seen + 1;
        if (err === 1'b1) err_seen = err_seen + 1;
    end

    typedef struct packed {
        logic [31:0] val;
        logic [7:0]  sel;
        logic        rev;
        logic [31:0] exp_dig;
        logic [7:0]  exp_valid;
    } frame_vec_t;

    frame_vec_t vecs[5];

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 8'hfc;
            4'd1: return 8'h60;
            4'd2: return 8'hda;
            4'd3: return 8'hf2;
            4'd4: return 8'h66;
            4'd5: return 8'hb6;
            4'd6: return 8'hbe;
            4'd7: return 8'he0;
            4'd8: return 8'hfe;
            4'd9: return 8'hf6;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // The unselected bus carries the complement so a wrong bus choice decodes as garbage
    task automatic drive(input logic [7:0] a, input logic [7:0] pat);
        an = a;
        if (a[7:4] != 4'd0) begin
            segout_1 = pat;
            segout_0 = ~pat;
        end else begin
            segout_0 = pat;
            segout_1 = ~pat;
        end
    endtask

    task automatic blank();
        an       = 8'h00;
        segout_0 = 8'h00;
        segout_1 = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        blank();
        step();
        step();
        rst = 1'b0;
    endtask

    // Present selected digits one per cycle, then blank
    task automatic present(input logic [31:0] vals, input logic [7:0] sel, input logic rev);
        int k;
        logic [3:0] v;
        for (int j = 0; j < 8; j++) begin
            k = rev ? 7 - j : j;
            if (sel[k]) begin
                v = vals[k*4 +: 4];
                drive(8'(1 << k), seg_of(v));
                step();
            end
        end
        blank();
    endtask

    // Called one cycle after the final digit; frame_done must appear exactly two cycles later
    task automatic frame_check(input string name, input logic [31:0] exp_dig, input logic [7:0] exp_valid);
        step();
        @(negedge clk);
        check({name, " early_frame_done"}, 32'(frame_done), 32'd0);
        step();
        @(negedge clk);
        check({name, " frame_done"}, 32'(frame_done), 32'd1);
        check({name, " digits"}, dig_bus, exp_dig);
        check({name, " valid"}, 32'(digit_valid), 32'(exp_valid));
        step();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fd0, st0, b, d1, d2;
        logic found;

        vecs[0] = '{val: 32'h76543210, sel: 8'hFF, rev: 1'b0, exp_dig: 32'h76543210, exp_valid: 8'hFF};
        vecs[1] = '{val: 32'h23456789, sel: 8'hFF, rev: 1'b1, exp_dig: 32'h23456789, exp_valid: 8'hFF};
        vecs[2] = '{val: 32'h99999999, sel: 8'hFF, rev: 1'b0, exp_dig: 32'h99999999, exp_valid: 8'hFF};
        vecs[3] = '{val: 32'h90909090, sel: 8'hFF, rev: 1'b1, exp_dig: 32'h90909090, exp_valid: 8'hFF};
        vecs[4] = '{val: 32'h00000000, sel: 8'hFF, rev: 1'b0, exp_dig: 32'h00000000, exp_valid: 8'hFF};

        // Reset state
        do_reset();
        @(negedge clk);
        check("reset digits", dig_bus, 32'd0);
        check("reset valid", 32'(digit_valid), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset stale", 32'(stale), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset err_count", 32'(err_count), 32'd0);
        step();

        // Table-driven full frames, back to back
        for (int i = 0; i < 5; i++) begin
            present(vecs[i].val, vecs[i].sel, vecs[i].rev);
            frame_check($sformatf("vec%0d", i), vecs[i].exp_dig, vecs[i].exp_valid);
            idle_cycles(3);
        end

        // Loopback scan: digits 1..8, 8 active + 8 blank cycles per scan
        do_reset();
        fd0 = fd_seen;
        b   = fd_cyc.size();
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 8; k++) begin
                drive(8'(1 << k), seg_of(4'(k + 1)));
                step();
            end
            blank();
            idle_cycles(8);
        end
        idle_cycles(2);
        check("loopback frame count", 32'(fd_seen - fd0), 32'd3);
        d1 = (fd_cyc.size() >= b + 3) ? fd_cyc[b+1] - fd_cyc[b] : -1;
        d2 = (fd_cyc.size() >= b + 3) ? fd_cyc[b+2] - fd_cyc[b+1] : -1;
        check("loopback period 1", 32'(d1), 32'd16);
        check("loopback period 2", 32'(d2), 32'd16);
        @(negedge clk);
        check("loopback digits", dig_bus, 32'h87654321);
        check("loopback valid", 32'(digit_valid), 32'hFF);
        step();

        // Overwrite: digit2 shown as 3 then 7 in the same frame
        do_reset();
        drive(8'h04, seg_of(4'd3)); step();
        drive(8'h01, seg_of(4'd0)); step();
        drive(8'h02, seg_of(4'd1)); step();
        drive(8'h04, seg_of(4'd7)); step();
        present(32'h76543000, 8'hF8, 1'b0);
        frame_check("overwrite", 32'h76543710, 8'hFF);

        // Timeout: partial frame abandoned, committed outputs held
        do_reset();
        present(32'h13572468, 8'hFF, 1'b0);
        frame_check("pre_timeout", 32'h13572468, 8'hFF);
        fd0 = fd_seen;
        st0 = st_seen;
        present(32'h00555555, 8'h3F, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (stale === 1'b1) found = 1'b1;
            else step();
        end
        check("timeout stale seen", 32'(found), 32'd1);
        check("timeout digits held", dig_bus, 32'h13572468);
        check("timeout valid held", 32'(digit_valid), 32'hFF);
        step();
        @(negedge clk);
        check("timeout stale one cycle", 32'(stale), 32'd0);
        step();
        check("timeout stale count", 32'(st_seen - st0), 32'd1);
        check("timeout no frame_done", 32'(fd_seen - fd0), 32'd0);
        // Mask was cleared: digits 6,7 alone must not complete a frame
        present(32'h24000000, 8'hC0, 1'b0);
        idle_cycles(8);
        check("timeout mask cleared", 32'(fd_seen - fd0), 32'd0);
        present(32'h00654321, 8'h3F, 1'b0);
        frame_check("post_timeout", 32'h24654321, 8'hFF);

        // Illegal samples
        do_reset();
        drive(8'h03, seg_of(4'd1)); step();
        blank(); step();
        @(negedge clk);
`ifdef SEG7_CAPTURE_ERR_EN
        check("err multi-hot pulse", 32'(err), 32'd1);
        check("err multi-hot count", 32'(err_count), 32'd1);
`else
        check("err multi-hot pulse", 32'(err), 32'd0);
        check("err multi-hot count", 32'(err_count), 32'd0);
`endif
        step();
        @(negedge clk);
        check("err pulse width", 32'(err), 32'd0);
        step();
        drive(8'h01, 8'h00); step();
        blank(); step();
        @(negedge clk);
`ifdef SEG7_CAPTURE_ERR_EN
        check("err bad pattern pulse", 32'(err), 32'd1);
        check("err bad pattern count", 32'(err_count), 32'd2);
`else
        check("err bad pattern pulse", 32'(err), 32'd0);
        check("err bad pattern count", 32'(err_count), 32'd0);
`endif
        step();
        fd0 = fd_seen;
        present(32'h76543210, 8'hFE, 1'b0);
`ifdef SEG7_CAPTURE_ERR_EN
        frame_check("err frame", 32'h7654321F, 8'hFE);
`else
        idle_cycles(8);
        check("err frame unaffected", 32'(fd_seen - fd0), 32'd0);
        present(32'h00000008, 8'h01, 1'b0);
        frame_check("err frame", 32'h76543218, 8'hFF);
`endif

        // Reset in the middle of a frame
        present(32'h00011111, 8'h1F, 1'b0);
        fd0 = fd_seen;
        do_reset();
        @(negedge clk);
        check("midreset digits", dig_bus, 32'd0);
        check("midreset valid", 32'(digit_valid), 32'd0);
        check("midreset err_count", 32'(err_count), 32'd0);
        step();
        present(32'h31400000, 8'hE0, 1'b0);
        idle_cycles(8);
        check("midreset no frame_done", 32'(fd_seen - fd0), 32'd0);
        present(32'h00015926, 8'h1F, 1'b0);
        frame_check("midreset next frame", 32'h31415926, 8'hFF);

        idle_cycles(2);
`ifdef SEG7_CAPTURE_ERR_EN
        check("total err pulses", 32'(err_seen), 32'd2);
`else
        check("total err pulses", 32'(err_seen), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
